// File: rtl/fifo_bank_mp.sv
// fifo_bank_mp: multi-port FIFO bank, NW write / NR read ports sharing one circular buffer
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   we/wdata      per-port write request and data (port i at [i*DW +: DW])
//   wready        one-hot (or zero) write-accept strobe
//   re            per-port read request
//   rdata         read data, only the granted port carries mem[raddr], others 0
//   rready        one-hot (or zero) read-accept strobe
//   full/empty/almost_full/almost_empty/count  occupancy status from the registered count
//
// Build option: define FIFO_BANK_RR_EN for round-robin arbitration on both sides;
// otherwise the lowest requesting index wins.
module fifo_bank_mp #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int NW    = 2,
    parameter int NR    = 2,
    parameter int AF_TH = 6,
    parameter int AE_TH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NW-1:0]    we,
    input  logic [NW*DW-1:0] wdata,
    output logic [NW-1:0]    wready,
    input  logic [NR-1:0]    re,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]    rready,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count
);
    localparam int CW  = AW + 1;
    localparam int WIW = NW > 1 ? $clog2(NW) : 1;
    localparam int RIW = NR > 1 ? $clog2(NR) : 1;
    localparam logic [AW:0] DEPTH = CW'(2 ** AW);
    localparam logic [AW:0] AF = CW'(AF_TH);
    localparam logic [AW:0] AE = CW'(AE_TH);

    logic [DW-1:0]  mem [2 ** AW];
    logic [AW-1:0]  waddr, raddr;
    logic [WIW-1:0] wsel;
    logic [RIW-1:0] rsel;
    logic [DW-1:0]  wd;
    logic           wr_ok, rd_ok;

    // Picks the requester closest after 'last' in circular order; last = -1
    // degenerates to plain lowest-index priority.
    function automatic int pick(input int req, input int last, input int n);
        int best;
        best = n;
        pick = 0;
        for (int i = 0; i < n; i++)
            if (req[i] && (i + n - last - 1) % n < best) begin
                best = (i + n - last - 1) % n;
                pick = i;
            end
    endfunction

`ifdef FIFO_BANK_RR_EN
    logic [WIW-1:0] wlast;
    logic [RIW-1:0] rlast;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wlast <= '0;
            rlast <= '0;
        end else begin
            if (wr_ok) wlast <= wsel;
            if (rd_ok) rlast <= rsel;
        end
    assign wsel = WIW'(pick(int'(we), int'(wlast), NW));
    assign rsel = RIW'(pick(int'(re), int'(rlast), NR));
`else
    assign wsel = WIW'(pick(int'(we), -1, NW));
    assign rsel = RIW'(pick(int'(re), -1, NR));
`endif

    // Reset gates acceptance so nothing is granted or written while rst is low.
    assign rd_ok = rst && (count != '0) && |re;
    assign wr_ok = rst && |we && ((count != DEPTH) || rd_ok);

    always_comb begin
        wd     = '0;
        wready = '0;
        rready = '0;
        rdata  = '0;
        for (int k = 0; k < NW; k++) begin
            wready[k] = wr_ok && (wsel == WIW'(k));
            wd        = (wsel == WIW'(k)) ? wdata[k*DW +: DW] : wd;
        end
        for (int j = 0; j < NR; j++) begin
            rready[j]         = rd_ok && (rsel == RIW'(j));
            rdata[j*DW +: DW] = rready[j] ? mem[raddr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            waddr <= '0;
            raddr <= '0;
            count <= '0;
        end else begin
            if (wr_ok) waddr <= waddr + 1'b1;
            if (rd_ok) raddr <= raddr + 1'b1;
            if (wr_ok != rd_ok) count <= wr_ok ? count + 1'b1 : count - 1'b1;
        end

    always_ff @(posedge clk)
        if (wr_ok) mem[waddr] <= wd;

    assign full         = !rst || (count == DEPTH);
    assign empty        = !rst || (count == '0);
    assign almost_full  = rst && (count >= AF);
    assign almost_empty = !rst || (count <= AE);
endmodule

// File: tb/tb_fifo_bank_mp.sv
// tb_fifo_bank_mp: scoreboard bench for fifo_bank_mp against a queue-based reference model
module tb_fifo_bank_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  we = '0, re = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  wready, rready;
    logic [15:0] rdata;
    logic        full, empty, almost_full, almost_empty;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  rr;
        logic [15:0] rd;
    } sb_t;

    logic [7:0] ref_q [$];
    sb_t        sb_q [$];
    sb_t        mon_e;
    int         lastw = 0, lastr = 0;

    fifo_bank_mp #(.DW(8), .AW(3), .NW(2), .NR(2), .AF_TH(6), .AE_TH(2)) dut (
        .clk(clk), .rst(rst), .we(we), .wdata(wdata), .wready(wready),
        .re(re), .rdata(rdata), .rready(rready), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int grant(input logic [1:0] req, input int last);
`ifdef FIFO_BANK_RR_EN
        for (int k = 1; k <= 2; k++)
            if (req[(last + k) % 2]) return (last + k) % 2;
`else
        for (int k = 0; k < 2; k++)
            if (req[k]) return k + 0 * last;
`endif
        return 0;
    endfunction

    // One cycle: apply requests, check acceptance and flags against the model,
    // queue the expected read response for the monitor.
    task automatic step(input logic [1:0] w, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] r);
        int cnt, gw, gr;
        bit wr, rd;
        sb_t e;
        @(posedge clk);
        #1;
        we = w; wdata = {d1, d0}; re = r;
        #1;
        cnt = ref_q.size();
        rd  = (cnt != 0) && (r != 0);
        wr  = (w != 0) && (cnt < 8 || rd);
        gw  = grant(w, lastw);
        gr  = grant(r, lastr);
        chk("wready", wready, wr ? (32'd1 << gw) : 32'd0);
        chk("count", count, cnt);
        chk("full", full, cnt == 8);
        chk("empty", empty, cnt == 0);
        chk("almost_full", almost_full, cnt >= 6);
        chk("almost_empty", almost_empty, cnt <= 2);
        if (rd) begin
            e.rr = 2'(1 << gr);
            e.rd = '0;
            e.rd[gr*8 +: 8] = ref_q.pop_front();
            sb_q.push_back(e);
            lastr = gr;
        end
        if (wr) begin
            ref_q.push_back(gw == 1 ? d1 : d0);
            lastw = gw;
        end
    endtask

    always @(negedge clk) begin
        mon_e.rr = '0;
        mon_e.rd = '0;
        if (sb_q.size() > 0) mon_e = sb_q.pop_front();
        if (|rready || |mon_e.rr) begin
            chk("rready", rready, mon_e.rr);
            chk("rdata", rdata, mon_e.rd);
        end else
            chk("rdata_idle", rdata, 0);
    end

    initial begin
        we = 2'b11; re = 2'b11; wdata = 16'h5AA5;
        #3;
        chk("rst_full", full, 1);
        chk("rst_empty", empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_count", count, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        #2;
        we = '0; re = '0;
        rst = 1'b1;
        #1;
        chk("rel_full", full, 0);
        chk("rel_empty", empty, 1);
        chk("rel_ae", almost_empty, 1);
        chk("rel_wready", wready, 0);
        chk("rel_rready", rready, 0);
        chk("rel_rdata", rdata, 0);

        for (int i = 1; i <= 8; i++) step(2'b01, 8'(8'h11 * i), 8'h00, 2'b00);
        for (int i = 0; i < 8; i++) step(2'b00, 8'h00, 8'h00, 2'b10);
        step(2'b00, 8'h00, 8'h00, 2'b00);

        step(2'b11, 8'hA5, 8'h5A, 2'b00);
        step(2'b10, 8'hA5, 8'h5A, 2'b00);
        step(2'b00, 8'h00, 8'h00, 2'b01);
        step(2'b00, 8'h00, 8'h00, 2'b01);

        for (int i = 0; i < 8; i++) step(2'b01, 8'($urandom), 8'h00, 2'b00);
        step(2'b01, 8'hC3, 8'h00, 2'b01);
        step(2'b01, 8'h3C, 8'h00, 2'b00);
        for (int i = 0; i < 8; i++) step(2'b00, 8'h00, 8'h00, 2'b01);
        step(2'b00, 8'h00, 8'h00, 2'b11);

        for (int i = 0; i < 300; i++)
            step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
        for (int i = 0; i < 8; i++) step(2'b00, 8'h00, 8'h00, 2'b11);

        for (int i = 0; i < 6; i++) step(2'b11, 8'($urandom), 8'($urandom), 2'b01);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 1);
        chk("mid_rst_wready", wready, 0);
        ref_q.delete();
        lastw = 0;
        lastr = 0;
        @(negedge clk);
        #2;
        we = '0; re = '0;
        rst = 1'b1;
        step(2'b00, 8'h00, 8'h00, 2'b11);
        step(2'b01, 8'h77, 8'h00, 2'b00);
        step(2'b00, 8'h00, 8'h00, 2'b10);
        step(2'b00, 8'h00, 8'h00, 2'b00);
        @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
